// File: rtl/arb_requester.sv
// Queued requester for a round-robin arbiter: FIFO of pending payloads, req while non-empty.
// Optional starvation detection is compiled in with `define ARB_REQ_TIMEOUT_EN.
module arb_requester #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       req,
  input  logic                       gnt,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       starve
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT+1);
  typedef enum logic [1:0] {IDLE, REQUEST, STARVED} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQUEST} state_t;
`endif

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               push, pop;
`ifdef ARB_REQ_TIMEOUT_EN
  logic [WAIT_W-1:0]  wait_q, wait_d;
`endif

  // Flow control and bus outputs decode registered state; gnt only gates the transfer
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign req       = (count_q != '0);
  assign out_valid = req && gnt;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

`ifdef ARB_REQ_TIMEOUT_EN
  assign starve = (state_q == STARVED);
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    push     = in_valid && in_ready;
    pop      = req && gnt;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    state_d  = state_q;
`ifdef ARB_REQ_TIMEOUT_EN
    wait_d = wait_q;
    if (pop) begin
      wait_d = '0;
    end else if (req && (wait_q != WAIT_W'(TIMEOUT))) begin
      wait_d = wait_q + WAIT_W'(1);
    end
`endif
    case (state_q)
      IDLE: begin
        if (push) state_d = REQUEST;
      end
      REQUEST: begin
        if (pop && (count_d == '0)) begin
          state_d = IDLE;
`ifdef ARB_REQ_TIMEOUT_EN
        end else if (!gnt && (wait_q == WAIT_W'(TIMEOUT-1))) begin
          state_d = STARVED;
`endif
        end
      end
`ifdef ARB_REQ_TIMEOUT_EN
      STARVED: begin
        if (pop) state_d = (count_d == '0) ? IDLE : REQUEST;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_q   <= wait_d;
`endif
    end
  end

  // Payload storage needs no reset: entries are only read while counted
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits.
REQ-002 Parameter DEPTH, default 4, pending-entry queue depth; power of two, >= 2.
REQ-003 Parameter TIMEOUT, default 16, wait cycles before starvation is flagged; >= 2.
REQ-004 Port clk  input  1  single clock; all state on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  upstream has a payload.
REQ-007 Port in_ready  output  1  queue can accept a payload.
REQ-008 Port in_data  input  DATA_W  upstream payload.
REQ-009 Port req  output  1  request to the round-robin arbiter.
REQ-010 Port gnt  input  1  this client's grant bit from the arbiter.
REQ-011 Port out_valid  output  1  payload is on the shared bus this cycle.
REQ-012 Port out_data  output  DATA_W  payload driven to the shared bus.
REQ-013 Port count  output  $clog2(DEPTH+1)  number of queued entries.
REQ-014 Port starve  output  1  starvation flag; 0 when ARB_REQ_TIMEOUT_EN is undefined.

Function
REQ-015 The queue SHALL be FIFO-ordered; a push occurs on a rising edge with in_valid && in_ready.
REQ-016 in_ready SHALL equal (count < DEPTH), registered-state only, with no combinational path from gnt.
REQ-017 req SHALL equal (count != 0), decoded from registered state; it SHALL stay high until the head entry is granted.
REQ-018 Because the arbiter grant is combinational from req, a transfer SHALL complete in the same cycle as req && gnt: out_valid = req && gnt, out_data = head entry.
REQ-019 On a rising edge with req && gnt the head SHALL pop; an entry pushed at edge N SHALL raise req no earlier than cycle N+1.
REQ-020 gnt while req is 0 SHALL be ignored: no pop, out_valid 0, no state change.
REQ-021 Simultaneous push and pop SHALL keep count unchanged and preserve order, including when count == DEPTH-1.
REQ-022 When full, push SHALL be blocked even if the head is granted in the same cycle.
REQ-023 out_data SHALL be don't-care while out_valid is 0.
REQ-024 FSM states: IDLE (count 0), REQUEST (count > 0, waiting), STARVED (compiled only with ARB_REQ_TIMEOUT_EN).
REQ-025 Transitions: IDLE->REQUEST on push. REQUEST->IDLE on pop leaving count 0. REQUEST->STARVED when the wait counter reaches TIMEOUT. STARVED->REQUEST or IDLE on grant, by resulting count.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 rst_n low SHALL asynchronously empty the queue and force count=0, req=0, out_valid=0, in_ready=1, starve=0, state IDLE, wait counter 0.
REQ-028 Reset mid-operation SHALL discard all queued entries; after reset releases, the first req SHALL be caused only by a new push.

Configuration
REQ-029 Macro ARB_REQ_TIMEOUT_EN SHALL compile in a wait counter of width $clog2(TIMEOUT+1).
REQ-030 With ARB_REQ_TIMEOUT_EN defined:
- The counter SHALL increment each cycle with req && !gnt and saturate at TIMEOUT.
- A grant SHALL clear the counter.
- starve SHALL be 1 exactly in state STARVED.
REQ-031 Without ARB_REQ_TIMEOUT_EN, the counter and state STARVED SHALL be absent, starve SHALL be tied 0, and all other behaviour SHALL be identical.

Verification
REQ-032 Push A=0x11 at cycle 0, gnt held 1 -> req=1 at cycle 1, out_valid=1 with out_data=0x11 at cycle 1, count=0 and req=0 at cycle 2.
REQ-033 Push 0x1..0x4 with gnt=0 -> count=4, in_ready=0, a fifth push is refused; then gnt=1 for 4 cycles -> outputs 0x1,0x2,0x3,0x4 in order.
REQ-034 count=3 (DEPTH 4), push and grant in the same cycle -> count stays 3 and order is preserved; at count=4, grant plus in_valid -> no push, count=3.
REQ-035 gnt=1 while the queue is empty -> out_valid=0, count=0, no state change.
REQ-036 ARB_REQ_TIMEOUT_EN defined, TIMEOUT=16, one entry queued, gnt=0 -> starve rises after 16 waiting cycles and clears on the edge after gnt=1; with the macro undefined, starve stays 0.
REQ-037 Queue 3 entries, then pulse rst_n low mid-cycle -> req, out_valid, count and starve drop to 0 immediately; no req after release until a new push.
